// File: rtl/drum_pkg.sv
// Shared constants for the drum synthesiser: scheduler state encoding, datapath widths and sample extraction.
// Used by the iteration scheduler, the column engines and the HPS register map.
package drum_pkg;

  localparam int NODE_W     = 18;
  localparam int SAMPLE_W   = 16;
  localparam int CNT_W      = 16;
  localparam int SAMPLE_MSB = 17;
  localparam int SAMPLE_LSB = 2;

  localparam logic [2:0] ST_INIT_RST  = 3'd0;
  localparam logic [2:0] ST_INIT_WAIT = 3'd1;
  localparam logic [2:0] ST_IDLE      = 3'd2;
  localparam logic [2:0] ST_WAIT_TICK = 3'd3;
  localparam logic [2:0] ST_ITER      = 3'd4;
  localparam logic [2:0] ST_WAIT_DONE = 3'd5;
  localparam logic [2:0] ST_PUSH      = 3'd6;

  typedef enum logic [2:0] {
    INIT_RST  = ST_INIT_RST,
    INIT_WAIT = ST_INIT_WAIT,
    IDLE      = ST_IDLE,
    WAIT_TICK = ST_WAIT_TICK,
    ITER      = ST_ITER,
    WAIT_DONE = ST_WAIT_DONE,
    PUSH      = ST_PUSH
  } state_t;

  function automatic logic state_busy(input state_t s);
    return (s == INIT_RST) || (s == INIT_WAIT) || (s == ITER) || (s == WAIT_DONE);
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running audio sample timebase: counts 0..SAMPLE_DIV-1 and raises tick for the wrap cycle.
// Tick is decoded straight from the counter (no added latency); the counter never stalls.
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 1042
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(SAMPLE_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/drum_iter_scheduler.sv
// Runs one column-array iteration per audio tick, captures the centre node and offers it to the audio FIFO.
// All outputs registered; a stalled FIFO holds the sample and ticks missed meanwhile count as overruns.
module drum_iter_scheduler #(
  parameter int NUM_COLS   = 32,
  parameter int SAMPLE_DIV = 1042,
  parameter int RST_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                cfg_strobe,
  input  logic [NUM_COLS-1:0] col_done,
  input  logic [17:0]         center_node,
  output logic                col_reset,
  output logic                iter_enable,
  output logic [15:0]         audio_data,
  output logic                audio_valid,
  input  logic                audio_ready,
  output logic [15:0]         iter_cycles,
  output logic [15:0]         overrun_cnt,
  output logic                busy
);

  import drum_pkg::*;

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

  logic tick;

  sample_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  state_t              state_q, state_d;
  logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]    cyc_cnt_q, cyc_cnt_d;
  logic                cfg_pend_q, cfg_pend_d;
  logic                col_reset_q, col_reset_d;
  logic                iter_enable_q, iter_enable_d;
  logic [SAMPLE_W-1:0] audio_data_q, audio_data_d;
  logic                audio_valid_q, audio_valid_d;
  logic [CNT_W-1:0]    iter_cycles_q, iter_cycles_d;
  logic [CNT_W-1:0]    overrun_cnt_q, overrun_cnt_d;
  logic                busy_q, busy_d;

  logic all_done, iter_done, go_init;
  logic unused_node_lsbs;

  assign unused_node_lsbs = ^center_node[SAMPLE_LSB-1:0];
  assign all_done  = &col_done;
  // Done is still high from the previous iteration right after iter_enable; ignore it until cyc_cnt reaches 2.
  assign iter_done = all_done && (cyc_cnt_q >= CNT_W'(2));

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cyc_cnt_d     = cyc_cnt_q;
    cfg_pend_d    = cfg_pend_q;
    col_reset_d   = col_reset_q;
    iter_enable_d = 1'b0;
    audio_data_d  = audio_data_q;
    audio_valid_d = audio_valid_q;
    iter_cycles_d = iter_cycles_q;
    overrun_cnt_d = overrun_cnt_q;
    go_init       = 1'b0;

    if (tick && (state_q == ITER || state_q == WAIT_DONE || state_q == PUSH) &&
        overrun_cnt_q != '1)
      overrun_cnt_d = overrun_cnt_q + 1'b1;

    case (state_q)
      INIT_RST: begin
        cfg_pend_d = 1'b0;
        if (rst_cnt_q == RST_LAST) begin
          state_d     = INIT_WAIT;
          col_reset_d = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      INIT_WAIT: begin
        if (cfg_strobe)    go_init = 1'b1;
        else if (all_done) state_d = IDLE;
      end
      IDLE: begin
        if (cfg_strobe) go_init = 1'b1;
        else if (run)   state_d = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (cfg_strobe) go_init = 1'b1;
        else if (!run)  state_d = IDLE;
        else if (tick) begin
          state_d       = ITER;
          iter_enable_d = 1'b1;
        end
      end
      ITER: begin
        cyc_cnt_d = CNT_W'(1);
        state_d   = WAIT_DONE;
        if (cfg_strobe) cfg_pend_d = 1'b1;
      end
      WAIT_DONE: begin
        if (iter_done) begin
          iter_cycles_d = cyc_cnt_q;
          audio_data_d  = center_node[SAMPLE_MSB:SAMPLE_LSB];
          if (cfg_pend_q || cfg_strobe) begin
            go_init = 1'b1;
          end else begin
            state_d       = PUSH;
            audio_valid_d = 1'b1;
          end
        end else begin
          if (cfg_strobe) cfg_pend_d = 1'b1;
          if (cyc_cnt_q != '1) cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      PUSH: begin
        if (cfg_strobe) begin
          go_init = 1'b1;
        end else if (audio_ready) begin
          audio_valid_d = 1'b0;
          state_d       = run ? WAIT_TICK : IDLE;
        end
      end
      default: go_init = 1'b1;
    endcase

    if (go_init) begin
      state_d       = INIT_RST;
      rst_cnt_d     = '0;
      cfg_pend_d    = 1'b0;
      col_reset_d   = 1'b1;
      audio_valid_d = 1'b0;
    end

    busy_d = state_busy(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= INIT_RST;
      rst_cnt_q     <= '0;
      cyc_cnt_q     <= '0;
      cfg_pend_q    <= 1'b0;
      col_reset_q   <= 1'b1;
      iter_enable_q <= 1'b0;
      audio_data_q  <= '0;
      audio_valid_q <= 1'b0;
      iter_cycles_q <= '0;
      overrun_cnt_q <= '0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      cyc_cnt_q     <= cyc_cnt_d;
      cfg_pend_q    <= cfg_pend_d;
      col_reset_q   <= col_reset_d;
      iter_enable_q <= iter_enable_d;
      audio_data_q  <= audio_data_d;
      audio_valid_q <= audio_valid_d;
      iter_cycles_q <= iter_cycles_d;
      overrun_cnt_q <= overrun_cnt_d;
      busy_q        <= busy_d;
    end
  end

  assign col_reset   = col_reset_q;
  assign iter_enable = iter_enable_q;
  assign audio_data  = audio_data_q;
  assign audio_valid = audio_valid_q;
  assign iter_cycles = iter_cycles_q;
  assign overrun_cnt = overrun_cnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_drum_iter_scheduler.sv
// Directed bench for drum_iter_scheduler with a behavioural column array of programmable latency.
// Expected values are hand-derived from the 1042-cycle tick period and the chosen column latencies.
module tb_drum_iter_scheduler;

  localparam int NUM_COLS = 32;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                run = 1'b0;
  logic                cfg_strobe = 1'b0;
  logic [NUM_COLS-1:0] col_done = '0;
  logic [17:0]         center_node = '0;
  logic                audio_ready = 1'b1;
  logic                col_reset, iter_enable, audio_valid, busy;
  logic [15:0]         audio_data, iter_cycles, overrun_cnt;

  drum_iter_scheduler #(
    .NUM_COLS  (NUM_COLS),
    .SAMPLE_DIV(1042),
    .RST_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .cfg_strobe (cfg_strobe),
    .col_done   (col_done),
    .center_node(center_node),
    .col_reset  (col_reset),
    .iter_enable(iter_enable),
    .audio_data (audio_data),
    .audio_valid(audio_valid),
    .audio_ready(audio_ready),
    .iter_cycles(iter_cycles),
    .overrun_cnt(overrun_cnt),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Column array model: done drops on iter_enable and returns lat cycles later.
  int cyc = 0;
  int done_at = 10;
  int lat = 300;
  int ie_cnt = 0;
  int ie_last = 0;
  int av_cnt = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (reset) begin
      cyc      = 0;
      done_at  = 10;
      col_done = '0;
    end else begin
      cyc++;
      if (iter_enable) begin
        ie_cnt++;
        ie_last  = cyc;
        col_done = '0;
        done_at  = cyc + lat;
      end
      if (cyc == done_at) col_done = '1;
      if (audio_valid) av_cnt++;
    end
  end

  task automatic wait_ie(input string tag, input int prev);
    int w = 0;
    while (ie_cnt <= prev && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk(tag, 32'(ie_cnt > prev), 1);
  endtask

  task automatic wait_valid(input string tag);
    int w = 0;
    while (!audio_valid && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk(tag, audio_valid, 1);
  endtask

  task automatic wait_idle(input string tag);
    int w = 0;
    while ((busy || audio_valid) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    chk(tag, busy, 0);
  endtask

  task automatic measure_col_reset(output int n);
    int w = 0;
    n = 0;
    while (!col_reset && w < 3000) begin
      @(negedge clk);
      w++;
    end
    while (col_reset && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n, e1, c0, v0, t;
    logic [15:0] d0;
    logic stable;

    // T1: reset values, col_reset length, settle in IDLE
    repeat (3) @(negedge clk);
    chk("rst_col_reset", col_reset, 1);
    chk("rst_iter_enable", iter_enable, 0);
    chk("rst_audio_valid", audio_valid, 0);
    chk("rst_audio_data", audio_data, 0);
    chk("rst_iter_cycles", iter_cycles, 0);
    chk("rst_overrun", overrun_cnt, 0);
    chk("rst_busy", busy, 1);
    reset = 1'b0;
    measure_col_reset(n);
    chk("t1_col_reset_len", n, 4);
    chk("t1_busy_init_wait", busy, 1);
    repeat (20) @(negedge clk);
    chk("t1_idle_busy", busy, 0);
    chk("t1_no_iter", ie_cnt, 0);

    // T2: 300-cycle iterations, three centre-node patterns
    lat = 300;
    center_node = 18'h10000;
    run = 1'b1;
    c0 = ie_cnt;
    wait_ie("t2_ie1", c0);
    e1 = ie_last;
    wait_valid("t2_valid1");
    chk("t2_valid_latency", cyc - e1, 301);
    chk("t2_data1", audio_data, 16'h4000);
    chk("t2_iter_cycles", iter_cycles, 300);
    @(negedge clk);
    chk("t2_valid_drop", audio_valid, 0);
    center_node = 18'h2ABCD;
    wait_ie("t2_ie2", c0 + 1);
    chk("t2_period2", ie_last - e1, 1042);
    wait_valid("t2_valid2");
    chk("t2_data2", audio_data, 16'hAAF3);
    e1 = ie_last;
    center_node = 18'h3FFFF;
    wait_ie("t2_ie3", c0 + 2);
    chk("t2_period3", ie_last - e1, 1042);
    wait_valid("t2_valid3");
    chk("t2_data3", audio_data, 16'hFFFF);
    chk("t2_overrun", overrun_cnt, 0);
    run = 1'b0;
    wait_idle("t2_idle");

    // T3: 1500-cycle iterations miss one tick each
    lat = 1500;
    run = 1'b1;
    c0 = ie_cnt;
    wait_ie("t3_ie1", c0);
    e1 = ie_last;
    wait_ie("t3_ie2", c0 + 1);
    chk("t3_period2", ie_last - e1, 2084);
    chk("t3_overrun2", overrun_cnt, 1);
    e1 = ie_last;
    wait_ie("t3_ie3", c0 + 2);
    chk("t3_period3", ie_last - e1, 2084);
    chk("t3_overrun3", overrun_cnt, 2);
    run = 1'b0;
    wait_idle("t3_idle");
    chk("t3_overrun_end", overrun_cnt, 3);
    chk("t3_iter_cycles", iter_cycles, 1500);

    // T4: FIFO stalled 2000 cycles from iter_enable
    lat = 300;
    center_node = 18'h08000;
    run = 1'b1;
    c0 = ie_cnt;
    wait_ie("t4_ie1", c0);
    e1 = ie_last;
    audio_ready = 1'b0;
    wait_valid("t4_valid");
    d0 = audio_data;
    chk("t4_data", d0, 16'h2000);
    stable = 1'b1;
    while (cyc < e1 + 2000) begin
      @(negedge clk);
      if (!audio_valid || audio_data !== d0) stable = 1'b0;
    end
    chk("t4_hold_stable", stable, 1);
    chk("t4_no_iter_stalled", ie_cnt, c0 + 1);
    audio_ready = 1'b1;
    wait_ie("t4_ie2", c0 + 1);
    chk("t4_period", ie_last - e1, 2084);
    chk("t4_overrun", overrun_cnt, 4);
    run = 1'b0;
    wait_idle("t4_idle");

    // T5: cfg_strobe mid WAIT_DONE drops the sample and re-initialises
    lat = 450;
    center_node = 18'h1FFFC;
    run = 1'b1;
    c0 = ie_cnt;
    wait_ie("t5_ie", c0);
    e1 = ie_last;
    v0 = av_cnt;
    repeat (100) @(negedge clk);
    cfg_strobe = 1'b1;
    @(negedge clk);
    cfg_strobe = 1'b0;
    run = 1'b0;
    measure_col_reset(n);
    chk("t5_col_reset_len", n, 4);
    chk("t5_iter_cycles", iter_cycles, 450);
    wait_idle("t5_idle");
    chk("t5_no_valid", av_cnt - v0, 0);
    chk("t5_single_iter", ie_cnt, c0 + 1);

    // T6a: cfg_strobe on the same cycle as a tick while in WAIT_TICK
    t = e1 - 1;
    while (t <= cyc + 10) t += 1042;
    while (cyc < t - 5) @(negedge clk);
    run = 1'b1;
    c0 = ie_cnt;
    while (cyc < t) @(negedge clk);
    cfg_strobe = 1'b1;
    @(negedge clk);
    cfg_strobe = 1'b0;
    measure_col_reset(n);
    chk("t6_col_reset_len", n, 4);
    while (cyc < t + 20) @(negedge clk);
    chk("t6_no_iter", ie_cnt, c0);
    chk("t6_overrun", overrun_cnt, 4);

    // T6b: reset asserted while a sample is waiting in PUSH
    lat = 300;
    audio_ready = 1'b0;
    wait_ie("t6_ie", c0);
    wait_valid("t6_valid");
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", audio_valid, 0);
    chk("t6_rst_overrun", overrun_cnt, 0);
    chk("t6_rst_iter_cycles", iter_cycles, 0);
    chk("t6_rst_data", audio_data, 0);
    chk("t6_rst_col_reset", col_reset, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    audio_ready = 1'b1;
    c0 = ie_cnt;
    wait_ie("t6_ie_after_rst", c0);
    chk("t6_tick_restart", ie_last, 1042);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
